// File: rtl/zircon_led_pwm_logic.sv
// LED output driver: shadowed configuration applied at PWM period boundaries,
// with static, PWM, blink and breathe modes per enabled channel.
module zircon_led_pwm_logic #(
  parameter int LED_NUM       = 8,
  parameter int PWM_BITS      = 8,
  parameter int PRESC         = 16,
  parameter int BLINK_PERIODS = 64,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic                csi_clk,
  input  logic                rsi_reset_n,
  input  logic [LED_NUM-1:0]  led_data,
  input  logic [PWM_BITS-1:0] led_duty,
  input  logic [1:0]          led_mode,
  input  logic                led_control,
  output logic                led_pending,
  output logic                led_period,
  output logic [LED_NUM-1:0]  coe_led
);

  localparam int PRE_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int BLK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESC - 1);
  localparam logic [BLK_W-1:0]    BLK_LAST = BLK_W'(BLINK_PERIODS - 1);
  localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] MAX_M1   = MAX - 1'b1;
  localparam logic [PWM_BITS-1:0] ONE      = PWM_BITS'(1);
  localparam logic [LED_NUM-1:0]  OFF_LVL  = {LED_NUM{ACTIVE_LOW}};

  localparam logic [1:0] MODE_STATIC  = 2'b00;
  localparam logic [1:0] MODE_PWM     = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_BREATHE = 2'b11;

  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [BLK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [PWM_BITS-1:0] breath_duty_q, breath_duty_d;
  logic                breath_up_q, breath_up_d;

  logic [LED_NUM-1:0]  sh_data_q, sh_data_d;
  logic [PWM_BITS-1:0] sh_duty_q, sh_duty_d;
  logic [1:0]          sh_mode_q, sh_mode_d;
  logic [LED_NUM-1:0]  act_data_q, act_data_d;
  logic [PWM_BITS-1:0] act_duty_q, act_duty_d;
  logic [1:0]          act_mode_q, act_mode_d;

  logic                pending_q, pending_d;
  logic                period_q, period_d;
  logic [LED_NUM-1:0]  led_q, led_d;

  logic tick;
  logic period_end;
  logic apply;

  function automatic logic [LED_NUM-1:0] led_on(
    input logic [1:0]          mode,
    input logic [LED_NUM-1:0]  data,
    input logic [PWM_BITS-1:0] cnt,
    input logic [PWM_BITS-1:0] duty,
    input logic [PWM_BITS-1:0] bduty,
    input logic                phase
  );
    case (mode)
      MODE_STATIC: led_on = data;
      MODE_PWM:    led_on = (cnt < duty) ? data : '0;
      MODE_BLINK:  led_on = phase ? data : '0;
      default:     led_on = (cnt < bduty) ? data : '0;
    endcase
  endfunction

  always_comb begin
    tick       = (pre_cnt_q == PRE_LAST);
    period_end = tick && (pwm_cnt_q == MAX_M1);
    apply      = period_end && pending_q;

    pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;

    pwm_cnt_d = pwm_cnt_q;
    if (tick) begin
      pwm_cnt_d = (pwm_cnt_q == MAX_M1) ? '0 : pwm_cnt_q + 1'b1;
    end

    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (period_end) begin
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // A write in the same cycle as an apply lands in the shadow after the
    // old shadow has moved to active, so it stays pending.
    sh_data_d = sh_data_q;
    sh_duty_d = sh_duty_q;
    sh_mode_d = sh_mode_q;
    if (led_control) begin
      sh_data_d = led_data;
      sh_duty_d = led_duty;
      sh_mode_d = led_mode;
    end

    act_data_d = act_data_q;
    act_duty_d = act_duty_q;
    act_mode_d = act_mode_q;
    if (apply) begin
      act_data_d = sh_data_q;
      act_duty_d = sh_duty_q;
      act_mode_d = sh_mode_q;
    end

    pending_d = led_control ? 1'b1 : (apply ? 1'b0 : pending_q);
    period_d  = period_end;

    // Triangle wave: endpoints are each held for exactly one period.
    breath_duty_d = breath_duty_q;
    breath_up_d   = breath_up_q;
    if (apply && (sh_mode_q == MODE_BREATHE) && (act_mode_q != MODE_BREATHE)) begin
      breath_duty_d = '0;
      breath_up_d   = 1'b1;
    end else if (period_end && (act_mode_q == MODE_BREATHE)) begin
      if (breath_up_q) begin
        breath_duty_d = breath_duty_q + 1'b1;
        if (breath_duty_q == MAX_M1) breath_up_d = 1'b0;
      end else begin
        breath_duty_d = breath_duty_q - 1'b1;
        if (breath_duty_q == ONE) breath_up_d = 1'b1;
      end
    end

    led_d = led_on(act_mode_q, act_data_q, pwm_cnt_q, act_duty_q,
                   breath_duty_q, blink_phase_q) ^ OFF_LVL;
  end

  always_ff @(posedge csi_clk) begin
    if (!rsi_reset_n) begin
      pre_cnt_q     <= '0;
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      breath_duty_q <= '0;
      breath_up_q   <= 1'b1;
      sh_data_q     <= '0;
      sh_duty_q     <= '0;
      sh_mode_q     <= MODE_STATIC;
      act_data_q    <= '0;
      act_duty_q    <= '0;
      act_mode_q    <= MODE_STATIC;
      pending_q     <= 1'b0;
      period_q      <= 1'b0;
      led_q         <= OFF_LVL;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      breath_duty_q <= breath_duty_d;
      breath_up_q   <= breath_up_d;
      sh_data_q     <= sh_data_d;
      sh_duty_q     <= sh_duty_d;
      sh_mode_q     <= sh_mode_d;
      act_data_q    <= act_data_d;
      act_duty_q    <= act_duty_d;
      act_mode_q    <= act_mode_d;
      pending_q     <= pending_d;
      period_q      <= period_d;
      led_q         <= led_d;
    end
  end

  assign led_pending = pending_q;
  assign led_period  = period_q;
  assign coe_led     = led_q;

endmodule

// File: tb/tb_zircon_led_pwm_logic.sv
// Scoreboard bench for zircon_led_pwm_logic: stimulus pushes expected pin/flag
// values computed from period arithmetic; a monitor pops and compares each cycle.
module tb_zircon_led_pwm_logic;

  localparam int LED_NUM       = 8;
  localparam int PWM_BITS      = 4;
  localparam int PRESC         = 1;
  localparam int BLINK_PERIODS = 2;
  localparam bit ACTIVE_LOW    = 1'b1;
  localparam int MAXV          = (1 << PWM_BITS) - 1;
  localparam int PLEN          = PRESC * MAXV;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [LED_NUM-1:0]  data;
  logic [PWM_BITS-1:0] duty;
  logic [1:0]          mode;
  logic                ctl;
  logic                pending;
  logic                period;
  logic [LED_NUM-1:0]  coe;

  always #5 clk = ~clk;

  zircon_led_pwm_logic #(
    .LED_NUM(LED_NUM), .PWM_BITS(PWM_BITS), .PRESC(PRESC),
    .BLINK_PERIODS(BLINK_PERIODS), .ACTIVE_LOW(ACTIVE_LOW)
  ) dut (
    .csi_clk(clk), .rsi_reset_n(rst_n), .led_data(data), .led_duty(duty),
    .led_mode(mode), .led_control(ctl), .led_pending(pending),
    .led_period(period), .coe_led(coe)
  );

  typedef struct packed {
    logic [LED_NUM-1:0] coe;
    logic               pend;
    logic               per;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int passes = 0;

  // Reference model: time since reset decides counters, periods and phases.
  int                 n;
  logic [LED_NUM-1:0] m_sh_data, m_act_data;
  int                 m_sh_duty, m_act_duty;
  int                 m_sh_mode, m_act_mode;
  bit                 m_pend;
  int                 m_bstart;

  function automatic int tri_wave(input int k);
    int r;
    r = k % (2 * MAXV);
    return (r <= MAXV) ? r : (2 * MAXV - r);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
  endtask

  task automatic step(input bit r_n, input bit c, input logic [LED_NUM-1:0] d,
                      input logic [PWM_BITS-1:0] du, input logic [1:0] mo);
    exp_t e;
    int pwm, p, lvl;
    bit phase, pe, cond;
    rst_n = r_n; ctl = c; data = d; duty = du; mode = mo;
    if (!r_n) begin
      n = 0; m_sh_data = '0; m_act_data = '0; m_sh_duty = 0; m_act_duty = 0;
      m_sh_mode = 0; m_act_mode = 0; m_pend = 1'b0; m_bstart = 0;
      e.coe = {LED_NUM{ACTIVE_LOW}}; e.pend = 1'b0; e.per = 1'b0;
    end else begin
      pwm   = (n / PRESC) % MAXV;
      p     = n / PLEN;
      phase = ((p / BLINK_PERIODS) % 2) == 1;
      pe    = ((n + 1) % PLEN) == 0;
      case (m_act_mode)
        0:       cond = 1'b1;
        1:       cond = pwm < m_act_duty;
        2:       cond = phase;
        default: cond = pwm < tri_wave(p - m_bstart);
      endcase
      e.coe = (cond ? m_act_data : '0) ^ {LED_NUM{ACTIVE_LOW}};
      if (pe && m_pend) begin
        if (m_sh_mode == 3 && m_act_mode != 3) m_bstart = p + 1;
        m_act_data = m_sh_data; m_act_duty = m_sh_duty; m_act_mode = m_sh_mode;
        m_pend = 1'b0;
      end
      if (c) begin
        m_sh_data = d; m_sh_duty = int'(du); m_sh_mode = int'(mo); m_pend = 1'b1;
      end
      e.pend = m_pend; e.per = pe;
      n++;
    end
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++)
      step(1'b1, 1'b0, LED_NUM'($urandom), PWM_BITS'($urandom), 2'($urandom));
  endtask

  task automatic wr(input logic [LED_NUM-1:0] d, input logic [PWM_BITS-1:0] du,
                    input logic [1:0] mo);
    step(1'b1, 1'b1, d, du, mo);
  endtask

  task automatic to_pe();
    while (((n + 1) % PLEN) != 0) idle(1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("coe_led", 32'(coe), 32'(e.coe));
        chk("led_pending", 32'(pending), 32'(e.pend));
        chk("led_period", 32'(period), 32'(e.per));
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    logic [PWM_BITS-1:0] rd;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, 2'b00);
    idle(20);
    // static, then PWM at duty 4, 0 and full scale
    wr(8'hA5, 4'd0, 2'b00); idle(40);
    wr(8'h01, 4'd4, 2'b01); idle(45);
    wr(8'h01, 4'd0, 2'b01); idle(32);
    wr(8'h01, 4'd15, 2'b01); idle(32);
    // write colliding with a period boundary
    wr(8'hF0, 4'd0, 2'b00); to_pe();
    wr(8'h0F, 4'd7, 2'b01); idle(35);
    // two writes in one period
    wr(8'h11, 4'd0, 2'b00); idle(3); wr(8'h22, 4'd0, 2'b00); idle(35);
    // blink and breathe
    wr(8'hFF, 4'd0, 2'b10); idle(130);
    wr(8'h03, 4'd0, 2'b11); idle(MAXV * 36);
    // reset while a config is pending
    wr(8'hAA, 4'd0, 2'b00); idle(3);
    step(1'b0, 1'b0, '0, '0, 2'b00); step(1'b0, 1'b0, '0, '0, 2'b00);
    idle(40);
    // randomized traffic, including boundary collisions and resets
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 2))
        0:       rd = '0;
        1:       rd = PWM_BITS'(MAXV);
        default: rd = PWM_BITS'($urandom);
      endcase
      if ($urandom_range(0, 399) == 0) begin
        step(1'b0, 1'b0, LED_NUM'($urandom), rd, 2'($urandom));
      end else if ($urandom_range(0, 11) == 0 ||
                   (((n + 1) % PLEN) == 0 && $urandom_range(0, 2) == 0)) begin
        wr(LED_NUM'($urandom), rd, 2'($urandom));
      end else begin
        idle(1);
      end
    end
    idle(2);
    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
